pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (IF,ID,EX,M,WB). Collects per-stage stall

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_if.sv | 46 ++++
 rtl/hilo_busy_timer.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller and the PC mux.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_DRAIN    = 2'd1,
        HZ_REDIRECT = 2'd2
    } hz_state_t;

    // Exception vector the PC mux jumps to when PC_SelExc is asserted.
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of per-stage stall/exception requests and the stall/flush controls sent back
// to the pipeline registers.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned STALL_CNT_W = 32
) ();

    logic                   IF_StallReq;
    logic                   ID_StallReq;
    logic                   M_StallReq;
    logic                   M_Exception;
    logic                   EX_DivStart;
    logic                   EX_UsesHiLo;
    logic                   IF_Flush_Br;

    logic                   IF_Stall;
    logic                   ID_Stall;
    logic                   EX_Stall;
    logic                   M_Stall;
    logic                   WB_Stall;
    logic                   IF_Flush;
    logic                   ID_ExcFlush;
    logic                   EX_ExcFlush;
    logic                   M_ExcFlush;
    logic                   PC_SelExc;
    logic                   HiLo_Busy;
    logic [STALL_CNT_W-1:0] StallCycles;

    // Datapath side: raises requests, consumes stall/flush controls.
    modport master (
        output IF_StallReq, ID_StallReq, M_StallReq, M_Exception,
        output EX_DivStart, EX_UsesHiLo, IF_Flush_Br,
        input  IF_Stall, ID_Stall, EX_Stall, M_Stall, WB_Stall,
        input  IF_Flush, ID_ExcFlush, EX_ExcFlush, M_ExcFlush,
        input  PC_SelExc, HiLo_Busy, StallCycles
    );

    // Controller side.
    modport slave (
        input  IF_StallReq, ID_StallReq, M_StallReq, M_Exception,
        input  EX_DivStart, EX_UsesHiLo, IF_Flush_Br,
        output IF_Stall, ID_Stall, EX_Stall, M_Stall, WB_Stall,
        output IF_Flush, ID_ExcFlush, EX_ExcFlush, M_ExcFlush,
        output PC_SelExc, HiLo_Busy, StallCycles
    );

endinterface

// File: rtl/hilo_busy_timer.sv
// Tracks how long the multi-cycle divider/multiplier still owns HI/LO after a start pulse.
module hilo_busy_timer #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic busy_o,
    output logic last_o
);

    localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CntW'(DIV_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    // Final busy cycle: the result is forwardable, so HI/LO readers need not wait.
    assign last_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: back-propagates stall requests, runs the
// exception redirect FSM and tracks HI/LO ownership by the multi-cycle divider.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned STALL_CNT_W = 32
) (
    input logic                   CLK,
    input logic                   RST,
    pipeline_hazard_ctrl_if.slave hz
);

    hz_state_t              state_q, state_d;
    logic                   rst_dly_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic div_busy;
    logic div_last;
    logic div_load;
    logic redirect;
    logic out_en;
    logic ex_req;
    logic m_stall;
    logic ex_stall;
    logic id_stall;
    logic if_stall;
    logic if_flush;

    hilo_busy_timer #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_hilo_timer (
        .clk_i (CLK),
        .rst_i (RST),
        .load_i(div_load),
        .busy_o(div_busy),
        .last_o(div_last)
    );

    // Stall chain: a stall propagates backwards only; redirect overrides every request.
    always_comb begin
        redirect = (state_q == HZ_REDIRECT);
        out_en   = ~RST & ~rst_dly_q;
        // A new start needs HI/LO fully free; a reader may proceed in the divider's last cycle.
        ex_req   = hz.EX_DivStart ? div_busy : (hz.EX_UsesHiLo & div_busy & ~div_last);
        m_stall  = hz.M_StallReq & ~redirect;
        ex_stall = (ex_req & ~redirect) | m_stall;
        id_stall = (hz.ID_StallReq & ~redirect) | ex_stall;
        if_stall = (hz.IF_StallReq & ~redirect) | id_stall;
        if_flush = redirect | (hz.IF_Flush_Br & ~id_stall);
        div_load = hz.EX_DivStart & ~ex_stall & (state_q == HZ_RUN);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HZ_RUN: begin
                if (hz.M_Exception) begin
                    state_d = hz.M_StallReq ? HZ_DRAIN : HZ_REDIRECT;
                end
            end
            HZ_DRAIN: begin
                if (!hz.M_StallReq) begin
                    state_d = HZ_REDIRECT;
                end
            end
            HZ_REDIRECT: state_d = HZ_RUN;
            default:     state_d = HZ_RUN;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (out_en && if_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= HZ_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Keeps every output quiet for one extra cycle after reset is released.
    always_ff @(posedge CLK) begin
        rst_dly_q <= RST;
    end

    assign hz.IF_Stall    = out_en & if_stall;
    assign hz.ID_Stall    = out_en & id_stall;
    assign hz.EX_Stall    = out_en & ex_stall;
    assign hz.M_Stall     = out_en & m_stall;
    assign hz.WB_Stall    = 1'b0;
    assign hz.IF_Flush    = out_en & if_flush;
    assign hz.ID_ExcFlush = out_en & redirect;
    assign hz.EX_ExcFlush = out_en & redirect;
    assign hz.M_ExcFlush  = out_en & redirect;
    assign hz.PC_SelExc   = out_en & redirect;
    assign hz.HiLo_Busy   = out_en & div_busy;
    assign hz.StallCycles = out_en ? stall_cnt_q : '0;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned DivCycles = 4;
    localparam int unsigned CntW      = 6;
    localparam int          SatMax    = (1 << CntW) - 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    // Model state: flags for the exception sequence, remaining divider cycles, stall count.
    bit m_drain;
    bit m_redirect;
    bit m_rst_dly;
    int m_div_left;
    int m_stalls;

    pipeline_hazard_ctrl_if #(.STALL_CNT_W(CntW)) hz ();

    pipeline_hazard_ctrl #(
        .DIV_CYCLES (DivCycles),
        .STALL_CNT_W(CntW)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .hz (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, compare all outputs with the model, then advance the model past the edge.
    task automatic run_cycle(input logic r, input logic ifr, input logic idr, input logic mr,
                             input logic mexc, input logic dst, input logic uses,
                             input logic br);
        bit e_if, e_id, e_ex, e_m, e_fl, e_exc, e_busy, en;
        @(negedge clk);
        rst            = r;
        hz.IF_StallReq = ifr;
        hz.ID_StallReq = idr;
        hz.M_StallReq  = mr;
        hz.M_Exception = mexc;
        hz.EX_DivStart = dst;
        hz.EX_UsesHiLo = uses;
        hz.IF_Flush_Br = br;
        #1;
        en     = !r && !m_rst_dly;
        e_busy = (m_div_left > 0);
        if (m_redirect) begin
            {e_if, e_id, e_ex, e_m} = 4'b0000;
            e_fl  = 1'b1;
            e_exc = 1'b1;
        end else begin
            e_m   = mr;
            e_ex  = (dst ? (m_div_left > 0) : (uses && m_div_left > 1)) || e_m;
            e_id  = idr || e_ex;
            e_if  = ifr || e_id;
            e_fl  = br && !e_id;
            e_exc = 1'b0;
        end
        check_eq("stalls", {hz.IF_Stall, hz.ID_Stall, hz.EX_Stall, hz.M_Stall, hz.WB_Stall},
                 en ? {e_if, e_id, e_ex, e_m, 1'b0} : 5'b0);
        check_eq("flushes", {hz.IF_Flush, hz.ID_ExcFlush, hz.EX_ExcFlush, hz.M_ExcFlush},
                 en ? {e_fl, e_exc, e_exc, e_exc} : 4'b0);
        check_eq("pc_sel_exc", hz.PC_SelExc, en && e_exc);
        check_eq("hilo_busy", hz.HiLo_Busy, en && e_busy);
        check_eq("stall_cycles", hz.StallCycles, en ? m_stalls : 0);

        if (r) begin
            m_drain    = 0;
            m_redirect = 0;
            m_div_left = 0;
            m_stalls   = 0;
            m_rst_dly  = 1;
        end else begin
            if (en && e_if && m_stalls < SatMax) m_stalls++;
            if (!m_drain && !m_redirect && dst && !e_ex) m_div_left = DivCycles;
            else if (m_div_left > 0) m_div_left--;
            if (m_redirect) begin
                m_redirect = 0;
            end else if (m_drain) begin
                if (!mr) begin
                    m_drain    = 0;
                    m_redirect = 1;
                end
            end else if (mexc) begin
                if (mr) m_drain = 1;
                else m_redirect = 1;
            end
            m_rst_dly = 0;
        end
    endtask

    task automatic idle();
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        m_rst_dly      = 1;
        m_drain        = 0;
        m_redirect     = 0;
        m_div_left     = 0;
        m_stalls       = 0;
        rst            = 1'b1;
        hz.IF_StallReq = 1'b0;
        hz.ID_StallReq = 1'b0;
        hz.M_StallReq  = 1'b0;
        hz.M_Exception = 1'b0;
        hz.EX_DivStart = 1'b0;
        hz.EX_UsesHiLo = 1'b0;
        hz.IF_Flush_Br = 1'b0;

        run_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        // Memory stall back-propagates for 3 cycles.
        repeat (3) run_cycle(0, 0, 0, 1, 0, 0, 0, 0);
        idle();
        check_eq("t1_stall_cycles", hz.StallCycles, 3);

        // Divider start then an MFHI that waits for the result.
        run_cycle(0, 0, 0, 0, 0, 1, 1, 0);
        for (int t = 1; t <= 4; t++) begin
            run_cycle(0, 0, 0, 0, 0, 0, 1, 0);
            check_eq("t2_ex_stall", hz.EX_Stall, (t <= 3));
            check_eq("t2_busy", hz.HiLo_Busy, 1);
        end
        idle();
        check_eq("t2_busy_end", hz.HiLo_Busy, 0);

        // Exception with memory ready: redirect next cycle beats all requests.
        run_cycle(0, 0, 0, 0, 1, 0, 0, 0);
        run_cycle(0, 1, 1, 1, 0, 0, 0, 1);
        check_eq("t3_pc_sel", hz.PC_SelExc, 1);
        check_eq("t3_stalls", {hz.IF_Stall, hz.ID_Stall, hz.EX_Stall, hz.M_Stall}, 0);
        idle();
        check_eq("t3_pc_sel_end", hz.PC_SelExc, 0);

        // Exception while memory busy: drain, ignore second exception, then redirect.
        run_cycle(0, 0, 0, 1, 1, 0, 0, 0);
        run_cycle(0, 0, 0, 1, 0, 0, 0, 0);
        check_eq("t4_drain_pc", hz.PC_SelExc, 0);
        run_cycle(0, 0, 0, 0, 1, 0, 0, 0);
        check_eq("t4_drain_pc2", hz.PC_SelExc, 0);
        idle();
        check_eq("t4_redirect", hz.PC_SelExc, 1);
        idle();
        check_eq("t4_redirect_end", hz.PC_SelExc, 0);

        // Branch squash suppressed while ID is stalled.
        run_cycle(0, 0, 1, 0, 0, 0, 0, 1);
        check_eq("t5_flush_held", hz.IF_Flush, 0);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("t5_flush", hz.IF_Flush, 1);

        // Reset during DRAIN.
        run_cycle(0, 0, 0, 0, 0, 1, 1, 0);
        run_cycle(0, 0, 0, 1, 1, 0, 0, 0);
        run_cycle(0, 0, 0, 1, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check_eq("t6_pc_sel", hz.PC_SelExc, 0);
        idle();
        check_eq("t6_pc_sel2", hz.PC_SelExc, 0);
        check_eq("t6_busy", hz.HiLo_Busy, 0);
        check_eq("t6_stall_cycles", hz.StallCycles, 0);

        for (int i = 0; i < 2000; i++) begin
            run_cycle($urandom_range(199) == 0, $urandom_range(3) == 0,
                      $urandom_range(3) == 0, $urandom_range(2) == 0,
                      $urandom_range(11) == 0, $urandom_range(5) == 0,
                      $urandom_range(2) == 0, $urandom_range(3) == 0);
        end

        // Saturation of the stall counter.
        repeat (70) run_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check_eq("sat_stall_cycles", hz.StallCycles, SatMax);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
